fir_peak_monitor: RTL and testbench

Sink-side companion to the 3-channel FIR filter. It consumes the three 24-bit signed filter outputs and measures per-channel max, min and peak-to-peak over a fixed window of accepted samples. Results are presented channel-by-channel on a valid/ready readout port. It is used for on-chip amplitude checks of the filter response, for example passband versus stopband levels on a 16-sample sine stimulus.

---
 rtl/fir_peak_monitor.sv | 229 ++++++++++++++++++++++
 tb/tb_fir_peak_monitor.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_peak_monitor.sv
`timescale 1ns/1ps
// fir_peak_monitor: per-channel max/min/peak-to-peak over a window of accepted
// samples from the 3-channel FIR, read out one channel per valid/ready beat.
// Optional windowed mean output is enabled by defining FIR_PEAK_MON_MEAN_EN.
module fir_peak_monitor #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned WINDOW_LEN = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] data_ch0,
  input  logic signed [DATA_WIDTH-1:0] data_ch1,
  input  logic signed [DATA_WIDTH-1:0] data_ch2,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [1:0]                   res_ch,
  output logic signed [DATA_WIDTH-1:0] res_max,
  output logic signed [DATA_WIDTH-1:0] res_min,
  output logic [DATA_WIDTH:0]          res_p2p,
`ifdef FIR_PEAK_MON_MEAN_EN
  output logic signed [DATA_WIDTH-1:0] res_mean,
`endif
  output logic                         overrun,
  input  logic                         clr_overrun
);

  localparam int unsigned CntW = $clog2(WINDOW_LEN);
  localparam int unsigned SumW = DATA_WIDTH + CntW;

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   ch_q, ch_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic                         overrun_q, overrun_d;

  logic signed [DATA_WIDTH-1:0] sample [3];
  logic signed [DATA_WIDTH-1:0] max_q [3];
  logic signed [DATA_WIDTH-1:0] max_d [3];
  logic signed [DATA_WIDTH-1:0] min_q [3];
  logic signed [DATA_WIDTH-1:0] min_d [3];
  logic signed [DATA_WIDTH-1:0] snap_max_q [3];
  logic signed [DATA_WIDTH-1:0] snap_min_q [3];
`ifdef FIR_PEAK_MON_MEAN_EN
  logic signed [SumW-1:0]       sum_q [3];
  logic signed [SumW-1:0]       sum_d [3];
  logic signed [DATA_WIDTH-1:0] snap_mean_q [3];
  logic signed [DATA_WIDTH-1:0] sel_mean;
`endif

  logic                         first_smp;
  logic                         complete;
  logic                         hs;
  logic                         hs_last;
  logic                         load_snap;
  logic                         ovr_set;
  logic signed [DATA_WIDTH-1:0] sel_max;
  logic signed [DATA_WIDTH-1:0] sel_min;
  logic signed [DATA_WIDTH:0]   diff;

  assign first_smp = (cnt_q == '0);
  assign complete  = in_valid && (cnt_q == CntW'(WINDOW_LEN - 1));
  assign hs        = res_valid && res_ready;
  assign hs_last   = hs && (ch_q == 2'd2);
  // A window finishing on the ch2 handshake is accepted; otherwise DRAIN drops it.
  assign load_snap = complete && ((state_q == StIdle) || hs_last);
  assign ovr_set   = complete && (state_q == StDrain) && !hs_last;

  // Gather channel inputs and compute next accumulator values.
  always_comb begin
    sample[0] = data_ch0;
    sample[1] = data_ch1;
    sample[2] = data_ch2;
    cnt_d     = in_valid ? cnt_q + CntW'(1) : cnt_q;
    for (int i = 0; i < 3; i++) begin
      max_d[i] = max_q[i];
      min_d[i] = min_q[i];
`ifdef FIR_PEAK_MON_MEAN_EN
      sum_d[i] = sum_q[i];
`endif
      if (in_valid) begin
        if (first_smp) begin
          max_d[i] = sample[i];
          min_d[i] = sample[i];
`ifdef FIR_PEAK_MON_MEAN_EN
          sum_d[i] = {{CntW{sample[i][DATA_WIDTH-1]}}, sample[i]};
`endif
        end else begin
          if (sample[i] > max_q[i]) max_d[i] = sample[i];
          if (sample[i] < min_q[i]) min_d[i] = sample[i];
`ifdef FIR_PEAK_MON_MEAN_EN
          sum_d[i] = sum_q[i] + {{CntW{sample[i][DATA_WIDTH-1]}}, sample[i]};
`endif
        end
      end
    end
  end

  // Sample counter and running accumulators.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < 3; i++) begin
        max_q[i] <= '0;
        min_q[i] <= '0;
`ifdef FIR_PEAK_MON_MEAN_EN
        sum_q[i] <= '0;
`endif
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < 3; i++) begin
        max_q[i] <= max_d[i];
        min_q[i] <= min_d[i];
`ifdef FIR_PEAK_MON_MEAN_EN
        sum_q[i] <= sum_d[i];
`endif
      end
    end
  end

  // Snapshot of the completed window, including the completing sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        snap_max_q[i] <= '0;
        snap_min_q[i] <= '0;
`ifdef FIR_PEAK_MON_MEAN_EN
        snap_mean_q[i] <= '0;
`endif
      end
    end else if (load_snap) begin
      for (int i = 0; i < 3; i++) begin
        snap_max_q[i] <= max_d[i];
        snap_min_q[i] <= min_d[i];
`ifdef FIR_PEAK_MON_MEAN_EN
        // Upper bits of the sum are the floor-divided mean.
        snap_mean_q[i] <= sum_d[i][SumW-1:CntW];
`endif
      end
    end
  end

  // Readout state register, channel index and sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ch_q      <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      overrun_q <= overrun_d;
    end
  end

  // Readout next-state logic.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    overrun_d = ovr_set ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
    unique case (state_q)
      StIdle: begin
        if (complete) begin
          state_d = StDrain;
          ch_d    = 2'd0;
        end
      end
      StDrain: begin
        if (hs_last) begin
          state_d = complete ? StDrain : StIdle;
          ch_d    = 2'd0;
        end else if (hs) begin
          ch_d = ch_q + 2'd1;
        end
      end
      default: begin
        state_d = StIdle;
        ch_d    = 2'd0;
      end
    endcase
  end

  // Readout outputs: snapshot of the current channel while draining, else zero.
  always_comb begin
    sel_max = '0;
    sel_min = '0;
`ifdef FIR_PEAK_MON_MEAN_EN
    sel_mean = '0;
`endif
    if (state_q == StDrain) begin
      case (ch_q)
        2'd0: begin
          sel_max = snap_max_q[0];
          sel_min = snap_min_q[0];
`ifdef FIR_PEAK_MON_MEAN_EN
          sel_mean = snap_mean_q[0];
`endif
        end
        2'd1: begin
          sel_max = snap_max_q[1];
          sel_min = snap_min_q[1];
`ifdef FIR_PEAK_MON_MEAN_EN
          sel_mean = snap_mean_q[1];
`endif
        end
        default: begin
          sel_max = snap_max_q[2];
          sel_min = snap_min_q[2];
`ifdef FIR_PEAK_MON_MEAN_EN
          sel_mean = snap_mean_q[2];
`endif
        end
      endcase
    end
    diff      = {sel_max[DATA_WIDTH-1], sel_max} - {sel_min[DATA_WIDTH-1], sel_min};
    res_valid = (state_q == StDrain);
    res_ch    = ch_q;
    res_max   = sel_max;
    res_min   = sel_min;
    res_p2p   = diff;
    overrun   = overrun_q;
`ifdef FIR_PEAK_MON_MEAN_EN
    res_mean  = sel_mean;
`endif
  end

endmodule

// File: tb/tb_fir_peak_monitor.sv
`timescale 1ns/1ps
// Directed self-checking bench for fir_peak_monitor.
module tb_fir_peak_monitor;

  localparam int W = 24;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic signed [W-1:0] data_ch0, data_ch1, data_ch2;
  logic                res_valid;
  logic                res_ready;
  logic [1:0]          res_ch;
  logic signed [W-1:0] res_max, res_min;
  logic [W:0]          res_p2p;
  logic                overrun;
  logic                clr_overrun;
`ifdef FIR_PEAK_MON_MEAN_EN
  logic signed [W-1:0] res_mean;
`endif

  int total = 0;
  int bad   = 0;

  logic signed [W-1:0] emax [3];
  logic signed [W-1:0] emin [3];
  logic [W:0]          ep   [3];

  always #5 clk = ~clk;

  fir_peak_monitor #(.DATA_WIDTH(W), .WINDOW_LEN(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .data_ch0   (data_ch0),
    .data_ch1   (data_ch1),
    .data_ch2   (data_ch2),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_ch     (res_ch),
    .res_max    (res_max),
    .res_min    (res_min),
    .res_p2p    (res_p2p),
`ifdef FIR_PEAK_MON_MEAN_EN
    .res_mean   (res_mean),
`endif
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                       input logic signed [W-1:0] c);
    in_valid = v;
    data_ch0 = a;
    data_ch1 = b;
    data_ch2 = c;
  endtask

  task automatic test_reset();
    reset = 1'b1; res_ready = 1'b0; clr_overrun = 1'b0;
    drive(1'b0, '0, '0, '0);
    repeat (2) tick();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b want 0", res_valid); end
    total++; if (res_ch !== 2'd0) begin bad++; $display("FAIL reset_ch got %0d want 0", res_ch); end
    total++; if (res_max !== '0 || res_min !== '0 || res_p2p !== '0) begin
      bad++; $display("FAIL reset_fields got max=%0d min=%0d p2p=%0d want 0", res_max, res_min, res_p2p);
    end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got %0b want 0", overrun); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_constant();
    res_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, W'(1), W'(1), W'(1));
      tick();
      if (i == 14) begin
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL const_early got %0b want 0", res_valid); end
      end
    end
    in_valid = 1'b0;
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL const_latency got %0b want 1", res_valid); end
    for (int c = 0; c < 3; c++) begin
      total++;
      if (res_valid !== 1'b1 || res_ch !== 2'(c) || res_max !== W'(1) || res_min !== W'(1) || res_p2p !== '0) begin
        bad++; $display("FAIL const_beat%0d got v=%0b ch=%0d max=%0d min=%0d p2p=%0d want 1,%0d,1,1,0",
                        c, res_valid, res_ch, res_max, res_min, res_p2p, c);
      end
      tick();
    end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL const_end got %0b want 0", res_valid); end
  endtask

  task automatic test_sine();
    int lut [16] = '{0, 4194304, 7414554, 8388607, 8388607, 7414554, 4194304, 0,
                     0, -4194304, -7414554, -8388607, -8388607, -7414554, -4194304, 0};
    res_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, W'(lut[i]), W'(-8388608), (i % 2 == 0) ? W'(8388607) : W'(-8388608));
      tick();
    end
    in_valid = 1'b0;
    emax[0] = W'(8388607);  emin[0] = W'(-8388607); ep[0] = (W+1)'(16777214);
    emax[1] = W'(-8388608); emin[1] = W'(-8388608); ep[1] = '0;
    emax[2] = W'(8388607);  emin[2] = W'(-8388608); ep[2] = (W+1)'(16777215);
    for (int c = 0; c < 3; c++) begin
      total++;
      if (res_valid !== 1'b1 || res_ch !== 2'(c) || res_max !== emax[c] || res_min !== emin[c] ||
          res_p2p !== ep[c]) begin
        bad++; $display("FAIL sine_beat%0d got v=%0b ch=%0d max=%0d min=%0d p2p=%0d want max=%0d min=%0d p2p=%0d",
                        c, res_valid, res_ch, res_max, res_min, res_p2p, emax[c], emin[c], ep[c]);
      end
      tick();
    end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL sine_end got %0b want 0", res_valid); end
  endtask

  task automatic test_gaps();
    res_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) drive(1'b1, W'(i / 2 - 5), W'(-(i / 2) * 100), W'(7));
      else            drive(1'b0, W'(8388607), W'(-8388608), W'(8388607));
      tick();
      if (i == 29) begin
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL gaps_early got %0b want 0", res_valid); end
      end
      if (i == 30) begin
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL gaps_done got %0b want 1", res_valid); end
      end
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    emax[0] = W'(10); emin[0] = W'(-5);    ep[0] = (W+1)'(15);
    emax[1] = W'(0);  emin[1] = W'(-1500); ep[1] = (W+1)'(1500);
    emax[2] = W'(7);  emin[2] = W'(7);     ep[2] = '0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (res_valid !== 1'b1 || res_ch !== 2'(c) || res_max !== emax[c] || res_min !== emin[c] ||
          res_p2p !== ep[c]) begin
        bad++; $display("FAIL gaps_beat%0d got v=%0b ch=%0d max=%0d min=%0d p2p=%0d want max=%0d min=%0d p2p=%0d",
                        c, res_valid, res_ch, res_max, res_min, res_p2p, emax[c], emin[c], ep[c]);
      end
      tick();
    end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL gaps_end got %0b want 0", res_valid); end
  endtask

  task automatic test_overrun();
    res_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, W'(i), W'(-2 * i), (i == 7) ? W'(-50) : W'(20));
      tick();
    end
    total++; if (res_valid !== 1'b1 || overrun !== 1'b0) begin
      bad++; $display("FAIL ovr_w1 got v=%0b ovr=%0b want 1,0", res_valid, overrun);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, W'(1000 + i), W'(500), W'(-7));
      tick();
      if (i == 14) begin
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_early got %0b want 0", overrun); end
      end
    end
    in_valid = 1'b0;
    repeat (8) tick();
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got %0b want 1", overrun); end
    total++; if (res_valid !== 1'b1 || res_ch !== 2'd0 || res_max !== W'(15) || res_min !== W'(0)) begin
      bad++; $display("FAIL ovr_hold got v=%0b ch=%0d max=%0d min=%0d want 1,0,15,0",
                      res_valid, res_ch, res_max, res_min);
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got %0b want 0", overrun); end
    res_ready = 1'b1;
    emax[0] = W'(15); emin[0] = W'(0);   ep[0] = (W+1)'(15);
    emax[1] = W'(0);  emin[1] = W'(-30); ep[1] = (W+1)'(30);
    emax[2] = W'(20); emin[2] = W'(-50); ep[2] = (W+1)'(70);
    for (int c = 0; c < 3; c++) begin
      total++;
      if (res_valid !== 1'b1 || res_ch !== 2'(c) || res_max !== emax[c] || res_min !== emin[c] ||
          res_p2p !== ep[c]) begin
        bad++; $display("FAIL ovr_beat%0d got v=%0b ch=%0d max=%0d min=%0d p2p=%0d want max=%0d min=%0d p2p=%0d",
                        c, res_valid, res_ch, res_max, res_min, res_p2p, emax[c], emin[c], ep[c]);
      end
      tick();
    end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL ovr_end got %0b want 0", res_valid); end
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, W'(-i), W'(3), W'(i * i));
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      res_ready = (i >= 13);
      drive(1'b1, W'(2 * i), W'(-1), (i == 5) ? W'(8388607) : W'(-8388608));
      if (i == 13) begin
        total++; if (res_ch !== 2'd0 || res_max !== W'(0) || res_min !== W'(-15)) begin
          bad++; $display("FAIL b2b_w1 got ch=%0d max=%0d min=%0d want 0,0,-15", res_ch, res_max, res_min);
        end
      end
      tick();
      if (i == 14) begin
        total++; if (res_ch !== 2'd2 || res_max !== W'(225)) begin
          bad++; $display("FAIL b2b_ch2 got ch=%0d max=%0d want 2,225", res_ch, res_max);
        end
      end
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got %0b want 0", overrun); end
    emax[0] = W'(30);      emin[0] = W'(0);        ep[0] = (W+1)'(30);
    emax[1] = W'(-1);      emin[1] = W'(-1);       ep[1] = '0;
    emax[2] = W'(8388607); emin[2] = W'(-8388608); ep[2] = (W+1)'(16777215);
    for (int c = 0; c < 3; c++) begin
      total++;
      if (res_valid !== 1'b1 || res_ch !== 2'(c) || res_max !== emax[c] || res_min !== emin[c] ||
          res_p2p !== ep[c]) begin
        bad++; $display("FAIL b2b_beat%0d got v=%0b ch=%0d max=%0d min=%0d p2p=%0d want max=%0d min=%0d p2p=%0d",
                        c, res_valid, res_ch, res_max, res_min, res_p2p, emax[c], emin[c], ep[c]);
      end
      tick();
    end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got %0b want 0", res_valid); end
  endtask

  task automatic test_reset_midwindow();
    res_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, W'(5), W'(5), W'(5));
      tick();
    end
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, W'(50), W'(50), W'(50));
      tick();
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    total++; if (res_valid !== 1'b1 || res_ch !== 2'd1) begin
      bad++; $display("FAIL rst_middrain got v=%0b ch=%0d want 1,1", res_valid, res_ch);
    end
    #2;
    reset = 1'b1;
    #1;
    total++; if (res_valid !== 1'b0 || res_ch !== 2'd0 || res_max !== '0 || res_min !== '0 ||
                 res_p2p !== '0 || overrun !== 1'b0) begin
      bad++; $display("FAIL rst_async got v=%0b ch=%0d max=%0d min=%0d p2p=%0d ovr=%0b want all 0",
                      res_valid, res_ch, res_max, res_min, res_p2p, overrun);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, W'(-3), W'(-3), W'(-3));
      tick();
      if (i == 14) begin
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_fresh got %0b want 0", res_valid); end
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (res_valid !== 1'b1 || res_ch !== 2'(c) || res_max !== W'(-3) || res_min !== W'(-3) ||
          res_p2p !== '0) begin
        bad++; $display("FAIL rst_beat%0d got v=%0b ch=%0d max=%0d min=%0d p2p=%0d want -3,-3,0",
                        c, res_valid, res_ch, res_max, res_min, res_p2p);
      end
`ifdef FIR_PEAK_MON_MEAN_EN
      total++; if (res_mean !== W'(-3)) begin bad++; $display("FAIL rst_mean%0d got %0d want -3", c, res_mean); end
`endif
      tick();
    end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_end got %0b want 0", res_valid); end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_sine();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_reset_midwindow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
